// File: rtl/calc_res_uart_packer.sv
`default_nettype none
// ============================================================================
// Module   : calc_res_uart_packer
// Purpose  : Buffers 512-bit accelerator result beats in a small FIFO and
//            serialises each beat for the debug UART as one header word
//            {HDR_TAG, seq} followed by sixteen 32-bit data words, LSW first.
//            A net_finish pulse arms a trailer word {TRL_TAG, frame_cnt}.
//            The trailer goes out once the FIFO has drained.
// Ports    : clk, rst (sync, active-high)
//            calc_res_vld/calc_res  - result beat in (dropped when full)
//            net_finish             - frame-end pulse
//            uart_rdreq             - UART pulls the next word
//            uart_start             - 1-cycle pulse, a new beat header is up
//            uart_out_vld/uart_out  - word out, 1 cycle after an accepted req
//            fifo_full, ovf_cnt     - FIFO status, saturating drop counter
//            beat_seq               - sequence number of the current beat
//            busy                   - work outstanding
// Revision : 1.0 - initial release
// ============================================================================
module calc_res_uart_packer #(
    parameter int          DEPTH   = 4,
    parameter logic [15:0] HDR_TAG = 16'hA55A,
    parameter logic [15:0] TRL_TAG = 16'h5AA5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         calc_res_vld,
    input  logic [511:0] calc_res,
    input  logic         net_finish,
    input  logic         uart_rdreq,
    output logic         uart_start,
    output logic         uart_out_vld,
    output logic [31:0]  uart_out,
    output logic         fifo_full,
    output logic [15:0]  ovf_cnt,
    output logic [15:0]  beat_seq,
    output logic         busy
);

    localparam int         c_AW       = $clog2(DEPTH);
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HEAD  = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_TRAIL = 2'd3;

    logic [511:0]    r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic [1:0]      r_state;
    logic [3:0]      r_idx;
    logic [15:0]     r_seq;
    logic [15:0]     r_frame_cnt;
    logic [15:0]     r_ovf_cnt;
    logic            r_trailer_pend;
    logic            r_uart_start;
    logic            r_uart_out_vld;
    logic [31:0]     r_uart_out;

    logic            w_full;
    logic            w_push;
    logic            w_accept;
    logic            w_pop;
    logic [511:0]    w_head;
    logic [31:0]     w_word;

    assign w_full   = (r_count == (c_AW+1)'(DEPTH));
    // A pop in the same cycle never frees a slot for a beat arriving while full.
    assign w_push   = calc_res_vld & ~w_full;
    // Requests are ignored in IDLE and while the previous word is still being presented.
    assign w_accept = uart_rdreq & ~r_uart_out_vld & (r_state != c_ST_IDLE);
    assign w_pop    = w_accept & (r_state == c_ST_DATA) & (r_idx == 4'd15);
    assign w_head   = r_mem[r_rd_ptr];

    always_comb begin
        w_word = 32'd0;
        case (r_state)
            c_ST_HEAD:  w_word = {HDR_TAG, r_seq};
            c_ST_DATA:  w_word = w_head[{r_idx, 5'd0} +: 32];
            c_ST_TRAIL: w_word = {TRL_TAG, r_frame_cnt};
            default:    w_word = 32'd0;
        endcase
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= calc_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_ovf_cnt <= 16'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (calc_res_vld && w_full && (r_ovf_cnt != 16'hFFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_idx          <= 4'd0;
            r_seq          <= 16'd0;
            r_frame_cnt    <= 16'd0;
            r_trailer_pend <= 1'b0;
            r_uart_start   <= 1'b0;
            r_uart_out_vld <= 1'b0;
            r_uart_out     <= 32'd0;
        end else begin
            r_uart_start   <= 1'b0;
            r_uart_out_vld <= 1'b0;

            if (w_accept) begin
                r_uart_out     <= w_word;
                r_uart_out_vld <= 1'b1;
            end

            // A finish landing on the cycle the trailer is taken re-arms it.
            if ((r_state == c_ST_TRAIL) && w_accept) begin
                r_trailer_pend <= net_finish;
            end else if (net_finish) begin
                r_trailer_pend <= 1'b1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (r_count != '0) begin
                        r_uart_start <= 1'b1;
                        r_state      <= c_ST_HEAD;
                    end else if (r_trailer_pend) begin
                        r_state <= c_ST_TRAIL;
                    end
                end
                c_ST_HEAD: begin
                    if (w_accept) begin
                        r_idx   <= 4'd0;
                        r_state <= c_ST_DATA;
                    end
                end
                c_ST_DATA: begin
                    if (w_accept) begin
                        r_idx <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            r_seq   <= r_seq + 16'd1;
                            r_state <= c_ST_IDLE;
                            if (r_frame_cnt != 16'hFFFF) begin
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                            end
                        end
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_frame_cnt <= 16'd0;
                        r_state     <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign uart_start   = r_uart_start;
    assign uart_out_vld = r_uart_out_vld;
    assign uart_out     = r_uart_out;
    assign fifo_full    = w_full;
    assign ovf_cnt      = r_ovf_cnt;
    assign beat_seq     = r_seq;
    assign busy         = (r_state != c_ST_IDLE) | (r_count != '0) | r_trailer_pend;

endmodule
`default_nettype wire
